// File: rtl/simple_bus_pkg.sv
// simple_bus_pkg: shared types and defaults for the simple_bus fabric
package simple_bus_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, BUSY} arb_state_e;
  localparam int SB_ADDR_W = 8;
  localparam int SB_MODE_W = 2;
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first request at or after ptr
module rr_pick import simple_bus_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int W = owner_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [W-1:0]     ptr,
  output logic             valid,
  output logic [W-1:0]     idx
);
  always_comb begin
    valid = 1'b0;
    idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      j = (int'(ptr) + k) % N_REQ;
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx = W'(j);
      end
    end
  end
endmodule

// File: rtl/simple_bus_arbiter.sv
// simple_bus_arbiter: round-robin owner of one simple_bus slave with timeout abort
module simple_bus_arbiter import simple_bus_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int MODE_W = SB_MODE_W,
  parameter int TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           m_req,
  input  logic [N_REQ-1:0]           m_start,
  input  logic [N_REQ*ADDR_W-1:0]    m_addr,
  input  logic [N_REQ*MODE_W-1:0]    m_mode,
  output logic [N_REQ-1:0]           m_gnt,
  output logic [N_REQ-1:0]           m_rdy,
  output logic [N_REQ-1:0]           m_err,
  output logic                       s_req,
  output logic                       s_start,
  output logic [ADDR_W-1:0]          s_addr,
  output logic [MODE_W-1:0]          s_mode,
  input  logic                       s_rdy,
  output logic [owner_w(N_REQ)-1:0]  owner,
  output logic                       busy
);
  localparam int OW = owner_w(N_REQ);
  arb_state_e state;
  logic [OW-1:0] ptr, nxt, pptr, pidx;
  logic [7:0] cnt;
  logic pv, tmo, rel;
  // re-arbitration after a release looks from owner+1 in the same cycle
  always_comb begin
    tmo = cnt == 8'(TIMEOUT - 1);
    nxt = (owner == OW'(N_REQ - 1)) ? '0 : owner + 1'b1;
    rel = (state == GRANT && !m_start[owner] && !m_req[owner]) || (state == BUSY && (s_rdy || tmo));
    pptr = (state == IDLE) ? ptr : nxt;
  end
  rr_pick #(.N_REQ(N_REQ), .W(OW)) u_pick (.req(m_req), .ptr(pptr), .valid(pv), .idx(pidx));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      owner <= '0;
      m_gnt <= '0;
      m_rdy <= '0;
      m_err <= '0;
      s_req <= 1'b0;
      s_start <= 1'b0;
      s_addr <= '0;
      s_mode <= '0;
      busy <= 1'b0;
    end else begin
      s_start <= 1'b0;
      m_rdy <= (state == BUSY && s_rdy) ? m_gnt : '0;
      m_err <= (state == BUSY && !s_rdy && tmo) ? m_gnt : '0;
      if (state == BUSY) cnt <= cnt + 8'd1;
      if (state == GRANT && m_start[owner]) begin
        s_addr <= m_addr[owner*ADDR_W +: ADDR_W];
        s_mode <= m_mode[owner*MODE_W +: MODE_W];
        s_start <= 1'b1;
        busy <= 1'b1;
        cnt <= '0;
        state <= BUSY;
      end
      if (rel) ptr <= nxt;
      if (rel || state == IDLE) begin
        state <= pv ? GRANT : IDLE;
        owner <= pv ? pidx : '0;
        m_gnt <= pv ? N_REQ'(1) << pidx : '0;
        s_req <= pv;
        busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_simple_bus_arbiter.sv
// tb_simple_bus_arbiter: directed scoreboard bench for simple_bus_arbiter
module tb_simple_bus_arbiter;
  localparam int N = 4;
  localparam int TO = 15;
  logic clk = 1'b0, rst_n = 1'b0, s_rdy = 1'b0;
  logic [N-1:0] m_req = '0, m_start = '0, m_gnt, m_rdy, m_err;
  logic [N*8-1:0] m_addr = '0;
  logic [N*2-1:0] m_mode = '0;
  logic s_req, s_start, busy;
  logic [7:0] s_addr;
  logic [1:0] s_mode, owner;
  int n_chk = 0, n_fail = 0, n;
  logic [9:0] sq[$];
  logic [7:0] eq[$];
  logic [9:0] se;
  logic [7:0] ee;

  simple_bus_arbiter #(.N_REQ(N), .ADDR_W(8), .MODE_W(2), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_start(m_start), .m_addr(m_addr),
    .m_mode(m_mode), .m_gnt(m_gnt), .m_rdy(m_rdy), .m_err(m_err), .s_req(s_req),
    .s_start(s_start), .s_addr(s_addr), .s_mode(s_mode), .s_rdy(s_rdy),
    .owner(owner), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("gnt_onehot", 32'($countones(m_gnt) <= 1), 1);
    if (s_start) begin
      if (sq.size() == 0) chk("s_start_unexpected", 32'(s_start), 0);
      else begin
        se = sq.pop_front();
        chk("s_addr", 32'(s_addr), 32'(se[9:2]));
        chk("s_mode", 32'(s_mode), 32'(se[1:0]));
      end
    end
    if (|{m_rdy, m_err}) begin
      if (eq.size() == 0) chk("pulse_unexpected", 32'({m_rdy, m_err}), 0);
      else begin
        ee = eq.pop_front();
        chk("rdy_err", 32'({m_rdy, m_err}), 32'(ee));
      end
    end
  endtask

  task automatic start(input int who, input logic [7:0] a);
    m_addr[who*8 +: 8] = a;
    m_mode[who*2 +: 2] = 2'(who + 1);
    m_start = N'(1) << who;
    sq.push_back({a, 2'(who + 1)});
    tick();
    m_start = '0;
  endtask

  task automatic xfer(input int who, input logic [7:0] a);
    start(who, a);
    s_rdy = 1'b1;
    eq.push_back({N'(1) << who, 4'b0});
    tick();
    s_rdy = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_outputs", 32'({m_gnt, m_rdy, m_err, s_req, s_start, s_addr, s_mode, owner, busy}), 0);
    rst_n = 1'b1;
    m_req = 4'b0001;
    tick();
    chk("first_gnt", 32'(m_gnt), 32'h1);
    chk("first_sreq", 32'(s_req), 1);
    start(0, 8'h3C);
    chk("busy_after_start", 32'(busy), 1);
    chk("s_addr_3c", 32'(s_addr), 32'h3C);
    s_rdy = 1'b1;
    eq.push_back({4'b0001, 4'b0});
    tick();
    s_rdy = 1'b0;
    m_req = '0;
    tick();
    chk("idle_gnt", 32'({m_gnt, s_req}), 0);

    do_reset();
    m_req = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("fair_owner", 32'(owner), 32'(i % 4));
      chk("fair_gnt", 32'(m_gnt), 32'(1 << (i % 4)));
      xfer(i % 4, 8'(8'h10 + i));
    end

    do_reset();
    m_req = 4'b0011;
    tick();
    start(0, 8'hA5);
    chk("b2b_before", 32'(m_gnt), 32'h1);
    s_rdy = 1'b1;
    eq.push_back({4'b0001, 4'b0});
    tick();
    s_rdy = 1'b0;
    chk("b2b_after", 32'(m_gnt), 32'h2);

    start(1, 8'h77);
    eq.push_back({4'b0, 4'b0010});
    n = 0;
    while (m_err == '0 && n < 30) begin
      tick();
      n++;
    end
    chk("timeout_cycles", 32'(n), TO);
    chk("timeout_next_gnt", 32'(m_gnt), 32'h1);

    m_req = 4'b0010;
    tick();
    chk("drop_gnt", 32'(m_gnt), 32'h2);
    chk("drop_no_start", 32'({s_start, busy}), 0);

    start(1, 8'hC3);
    eq.push_back({4'b0010, 4'b0});
    for (int i = 0; i < TO - 1; i++) tick();
    s_rdy = 1'b1;
    tick();
    s_rdy = 1'b0;
    chk("edge_rdy", 32'(m_rdy), 32'h2);
    chk("edge_no_err", 32'(m_err), 0);

    s_rdy = 1'b1;
    tick();
    s_rdy = 1'b0;
    chk("stray_rdy", 32'({m_rdy, m_err}), 0);
    m_start = 4'b0001;
    tick();
    m_start = '0;
    chk("nonowner_start", 32'({s_start, busy}), 0);

    start(1, 8'h5A);
    chk("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    m_req = '0;
    #1;
    chk("async_rst", 32'({m_gnt, m_rdy, m_err, s_req, s_start, s_addr, s_mode, owner, busy}), 0);
    tick();
    tick();
    rst_n = 1'b1;
    m_req = 4'b1111;
    tick();
    chk("ptr_after_rst", 32'({owner, m_gnt}), 32'({2'd0, 4'b0001}));
    tick();
    chk("sq_drained", 32'(sq.size()), 0);
    chk("eq_drained", 32'(eq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
